// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage OpenMIPS pipeline.
//
// Computes logic, shift, move, arithmetic and multiply results for the
// instruction held in the ID/EX register. Owns the HI/LO registers and a
// radix-2 restoring divider that takes 32 iterations.
//
// Optional build macro:
//   EX_MADD_EN - adds the two-cycle MADD/MADDU/MSUB/MSUBU accumulate ops.
//                When it is undefined, those opcodes give result 0, wen 0
//                and leave HI/LO unchanged.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_alu_op, i_alu_sel       operation subtype and result class
//   i_op_reg_0, i_op_reg_1    operands (op0 = rs or shamt, op1 = rt or imm)
//   i_reg_wen, i_reg_waddr    destination write enable / address from ID
//   o_fwd_*                   combinational result forwarded to ID
//   o_mem_*                   registered EX/MEM bundle (o_fwd_* one edge later)
//   o_hi, o_lo                HI/LO registers
//   o_stall_req               hold IF/ID/EX while a multi-cycle op runs
module ex_stage #(
  parameter int N_REG      = 32,
  parameter int N_REG_ADDR = 5,
  parameter int N_ALU_OP   = 8,
  parameter int N_ALU_SEL  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_ALU_OP-1:0]   i_alu_op,
  input  logic [N_ALU_SEL-1:0]  i_alu_sel,
  input  logic [N_REG-1:0]      i_op_reg_0,
  input  logic [N_REG-1:0]      i_op_reg_1,
  input  logic                  i_reg_wen,
  input  logic [N_REG_ADDR-1:0] i_reg_waddr,
  output logic                  o_fwd_wen,
  output logic [N_REG_ADDR-1:0] o_fwd_waddr,
  output logic [N_REG-1:0]      o_fwd_wdata,
  output logic                  o_mem_wen,
  output logic [N_REG_ADDR-1:0] o_mem_waddr,
  output logic [N_REG-1:0]      o_mem_wdata,
  output logic [N_REG-1:0]      o_hi,
  output logic [N_REG-1:0]      o_lo,
  output logic                  o_stall_req
);

  localparam int SHW = $clog2(N_REG);
  localparam int MSB = N_REG - 1;

  // Result classes
  localparam logic [N_ALU_SEL-1:0] SEL_LOGIC = N_ALU_SEL'(3'b001);
  localparam logic [N_ALU_SEL-1:0] SEL_SHIFT = N_ALU_SEL'(3'b010);
  localparam logic [N_ALU_SEL-1:0] SEL_MOVE  = N_ALU_SEL'(3'b011);
  localparam logic [N_ALU_SEL-1:0] SEL_ARITH = N_ALU_SEL'(3'b100);
  localparam logic [N_ALU_SEL-1:0] SEL_MUL   = N_ALU_SEL'(3'b101);

  // Operation subtypes
  localparam logic [N_ALU_OP-1:0] OP_AND   = N_ALU_OP'(8'b0010_0100);
  localparam logic [N_ALU_OP-1:0] OP_OR    = N_ALU_OP'(8'b0010_0101);
  localparam logic [N_ALU_OP-1:0] OP_XOR   = N_ALU_OP'(8'b0010_0110);
  localparam logic [N_ALU_OP-1:0] OP_NOR   = N_ALU_OP'(8'b0010_0111);
  localparam logic [N_ALU_OP-1:0] OP_SLL   = N_ALU_OP'(8'b0111_1100);
  localparam logic [N_ALU_OP-1:0] OP_SRL   = N_ALU_OP'(8'b0000_0010);
  localparam logic [N_ALU_OP-1:0] OP_SRA   = N_ALU_OP'(8'b0000_0011);
  localparam logic [N_ALU_OP-1:0] OP_MOVZ  = N_ALU_OP'(8'b0000_1010);
  localparam logic [N_ALU_OP-1:0] OP_MOVN  = N_ALU_OP'(8'b0000_1011);
  localparam logic [N_ALU_OP-1:0] OP_MFHI  = N_ALU_OP'(8'b0001_0000);
  localparam logic [N_ALU_OP-1:0] OP_MTHI  = N_ALU_OP'(8'b0001_0001);
  localparam logic [N_ALU_OP-1:0] OP_MFLO  = N_ALU_OP'(8'b0001_0010);
  localparam logic [N_ALU_OP-1:0] OP_MTLO  = N_ALU_OP'(8'b0001_0011);
  localparam logic [N_ALU_OP-1:0] OP_SLT   = N_ALU_OP'(8'b0010_1010);
  localparam logic [N_ALU_OP-1:0] OP_SLTU  = N_ALU_OP'(8'b0010_1011);
  localparam logic [N_ALU_OP-1:0] OP_ADD   = N_ALU_OP'(8'b0010_0000);
  localparam logic [N_ALU_OP-1:0] OP_ADDU  = N_ALU_OP'(8'b0010_0001);
  localparam logic [N_ALU_OP-1:0] OP_SUB   = N_ALU_OP'(8'b0010_0010);
  localparam logic [N_ALU_OP-1:0] OP_SUBU  = N_ALU_OP'(8'b0010_0011);
  localparam logic [N_ALU_OP-1:0] OP_ADDI  = N_ALU_OP'(8'b0101_0101);
  localparam logic [N_ALU_OP-1:0] OP_ADDIU = N_ALU_OP'(8'b0101_0110);
  localparam logic [N_ALU_OP-1:0] OP_CLZ   = N_ALU_OP'(8'b1011_0000);
  localparam logic [N_ALU_OP-1:0] OP_CLO   = N_ALU_OP'(8'b1011_0001);
  localparam logic [N_ALU_OP-1:0] OP_MULT  = N_ALU_OP'(8'b0001_1000);
  localparam logic [N_ALU_OP-1:0] OP_MULTU = N_ALU_OP'(8'b0001_1001);
  localparam logic [N_ALU_OP-1:0] OP_MADD  = N_ALU_OP'(8'b1010_0110);
  localparam logic [N_ALU_OP-1:0] OP_MADDU = N_ALU_OP'(8'b1010_1000);
  localparam logic [N_ALU_OP-1:0] OP_MSUB  = N_ALU_OP'(8'b1010_1010);
  localparam logic [N_ALU_OP-1:0] OP_MSUBU = N_ALU_OP'(8'b1010_1011);
  localparam logic [N_ALU_OP-1:0] OP_DIV   = N_ALU_OP'(8'b0001_1010);
  localparam logic [N_ALU_OP-1:0] OP_DIVU  = N_ALU_OP'(8'b0001_1011);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  div_state_t div_state, div_state_next;

  logic [N_REG-1:0]   hi, lo;
  logic [N_REG-1:0]   sum, diff, clz_cnt, clo_cnt, result;
  logic               ov_add, ov_sub, overflow, no_wb_op;
  logic [2*N_REG-1:0] prod_s, prod_u;
  logic [SHW-1:0]     shamt;
  logic               is_div, is_madd, div_start, madd_start, stall_req;

  // Divider datapath
  logic [N_REG-1:0]   div_q, div_r, div_d, op0_mag, op1_mag, q_final, r_final;
  logic [N_REG:0]     div_shift;
  logic [N_REG+1:0]   div_trial;
  logic [SHW-1:0]     div_cnt;
  logic               div_neg_q, div_neg_r, div_done_flag, div_signed;

  assign shamt = i_op_reg_0[SHW-1:0];
  assign sum   = i_op_reg_0 + i_op_reg_1;
  assign diff  = i_op_reg_0 - i_op_reg_1;
  assign ov_add = (i_op_reg_0[MSB] == i_op_reg_1[MSB]) && (sum[MSB] != i_op_reg_0[MSB]);
  assign ov_sub = (i_op_reg_0[MSB] != i_op_reg_1[MSB]) && (diff[MSB] != i_op_reg_0[MSB]);

  // Low 2N bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{N_REG{i_op_reg_0[MSB]}}, i_op_reg_0} * {{N_REG{i_op_reg_1[MSB]}}, i_op_reg_1};
  assign prod_u = {{N_REG{1'b0}}, i_op_reg_0} * {{N_REG{1'b0}}, i_op_reg_1};

  assign is_div  = (i_alu_op == OP_DIV) || (i_alu_op == OP_DIVU);
  assign is_madd = (i_alu_op == OP_MADD) || (i_alu_op == OP_MADDU) ||
                   (i_alu_op == OP_MSUB) || (i_alu_op == OP_MSUBU);

  // Highest set (clz) / clear (clo) bit wins because it is visited last.
  always_comb begin
    clz_cnt = N_REG'(N_REG);
    clo_cnt = N_REG'(N_REG);
    for (int unsigned i = 0; i < N_REG; i++) begin
      if (i_op_reg_0[i])  clz_cnt = N_REG'(N_REG - 1 - int'(i));
      if (!i_op_reg_0[i]) clo_cnt = N_REG'(N_REG - 1 - int'(i));
    end
  end

  always_comb begin
    result = '0;
    case (i_alu_sel)
      SEL_LOGIC: begin
        case (i_alu_op)
          OP_OR:   result = i_op_reg_0 | i_op_reg_1;
          OP_AND:  result = i_op_reg_0 & i_op_reg_1;
          OP_XOR:  result = i_op_reg_0 ^ i_op_reg_1;
          OP_NOR:  result = ~(i_op_reg_0 | i_op_reg_1);
          default: result = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (i_alu_op)
          OP_SLL:  result = i_op_reg_1 << shamt;
          OP_SRL:  result = i_op_reg_1 >> shamt;
          OP_SRA:  result = $unsigned($signed(i_op_reg_1) >>> shamt);
          default: result = '0;
        endcase
      end
      SEL_MOVE: begin
        case (i_alu_op)
          OP_MFHI:         result = hi;
          OP_MFLO:         result = lo;
          OP_MOVN, OP_MOVZ: result = i_op_reg_0;
          default:         result = '0;
        endcase
      end
      SEL_ARITH: begin
        case (i_alu_op)
          OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: result = sum;
          OP_SUB, OP_SUBU: result = diff;
          OP_SLT:  result = N_REG'($signed(i_op_reg_0) < $signed(i_op_reg_1));
          OP_SLTU: result = N_REG'(i_op_reg_0 < i_op_reg_1);
          OP_CLZ:  result = clz_cnt;
          OP_CLO:  result = clo_cnt;
          default: result = '0;
        endcase
      end
      SEL_MUL: result = prod_s[N_REG-1:0];
      default: result = '0;
    endcase
  end

  always_comb begin
    overflow = 1'b0;
    if ((i_alu_op == OP_ADD) || (i_alu_op == OP_ADDI)) overflow = ov_add;
    else if (i_alu_op == OP_SUB)                       overflow = ov_sub;
  end

  assign no_wb_op = (i_alu_op == OP_MULT) || (i_alu_op == OP_MULTU) || is_madd;

  // Divider control
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) div_state <= DIV_IDLE;
    else          div_state <= div_state_next;
  end

  always_comb begin
    div_state_next = div_state;
    div_start      = 1'b0;
    case (div_state)
      DIV_IDLE: begin
        if (is_div && (i_op_reg_1 != '0) && !div_done_flag) begin
          div_start      = 1'b1;
          div_state_next = DIV_BUSY;
        end
      end
      DIV_BUSY: if (div_cnt == '1) div_state_next = DIV_DONE;
      DIV_DONE: div_state_next = DIV_IDLE;
      default:  div_state_next = DIV_IDLE;
    endcase
  end

  assign div_signed = (i_alu_op == OP_DIV);
  assign op0_mag    = (div_signed && i_op_reg_0[MSB]) ? -i_op_reg_0 : i_op_reg_0;
  assign op1_mag    = (div_signed && i_op_reg_1[MSB]) ? -i_op_reg_1 : i_op_reg_1;
  assign div_shift  = {div_r, div_q[MSB]};
  assign div_trial  = {1'b0, div_shift} - {2'b00, div_d};
  assign q_final    = div_neg_q ? -div_q : div_q;
  assign r_final    = div_neg_r ? -div_r : div_r;

  // div_q starts as the dividend and is shifted out MSB-first while the
  // quotient bits shift in from the bottom.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_q     <= '0;
      div_r     <= '0;
      div_d     <= '0;
      div_cnt   <= '0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
    end else if (div_start) begin
      div_q     <= op0_mag;
      div_r     <= '0;
      div_d     <= op1_mag;
      div_cnt   <= '0;
      div_neg_q <= div_signed && (i_op_reg_0[MSB] != i_op_reg_1[MSB]);
      div_neg_r <= div_signed && i_op_reg_0[MSB];
    end else if (div_state == DIV_BUSY) begin
      div_q   <= {div_q[N_REG-2:0], ~div_trial[N_REG+1]};
      div_r   <= div_trial[N_REG+1] ? div_shift[N_REG-1:0] : div_trial[N_REG-1:0];
      div_cnt <= div_cnt + SHW'(1);
    end
  end

  // Blocks re-execution of the DIV still sitting in ID/EX right after DONE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                   div_done_flag <= 1'b0;
    else if (div_state == DIV_DONE)                 div_done_flag <= 1'b1;
    else if ((div_state == DIV_IDLE) && !stall_req) div_done_flag <= 1'b0;
  end

`ifdef EX_MADD_EN
  logic               madd_phase, madd_sub;
  logic [2*N_REG-1:0] madd_prod;

  assign madd_start = is_madd && !madd_phase;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      madd_phase <= 1'b0;
      madd_sub   <= 1'b0;
      madd_prod  <= '0;
    end else if (madd_start) begin
      madd_phase <= 1'b1;
      madd_sub   <= (i_alu_op == OP_MSUB) || (i_alu_op == OP_MSUBU);
      madd_prod  <= ((i_alu_op == OP_MADD) || (i_alu_op == OP_MSUB)) ? prod_s : prod_u;
    end else begin
      madd_phase <= 1'b0;
    end
  end
`else
  assign madd_start = 1'b0;
`endif

  assign stall_req = div_start || (div_state == DIV_BUSY) || madd_start;

  // HI/LO: divider DONE > MADD accumulate > MULT/MULTU > MTHI/MTLO
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (div_state == DIV_DONE) begin
      hi <= r_final;
      lo <= q_final;
`ifdef EX_MADD_EN
    end else if (madd_phase) begin
      {hi, lo} <= madd_sub ? ({hi, lo} - madd_prod) : ({hi, lo} + madd_prod);
`endif
    end else if (!stall_req) begin
      case (i_alu_op)
        OP_MULT:  {hi, lo} <= prod_s;
        OP_MULTU: {hi, lo} <= prod_u;
        OP_MTHI:  hi <= i_op_reg_0;
        OP_MTLO:  lo <= i_op_reg_0;
        default:  ;
      endcase
    end
  end

  assign o_fwd_wen   = i_reg_wen && !stall_req && !overflow && !no_wb_op;
  assign o_fwd_waddr = i_reg_waddr;
  assign o_fwd_wdata = result;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mem_wen   <= 1'b0;
      o_mem_waddr <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_mem_wen   <= o_fwd_wen;
      o_mem_waddr <= o_fwd_waddr;
      o_mem_wdata <= o_fwd_wdata;
    end
  end

  assign o_hi        = hi;
  assign o_lo        = lo;
  assign o_stall_req = stall_req;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: reset, ALU ops, HI/LO moves, MULT,
// the iterative divider (including reset abort) and MADD (with or without
// EX_MADD_EN).
module tb_ex_stage;

  localparam logic [2:0] S_NOP   = 3'b000;
  localparam logic [2:0] S_LOGIC = 3'b001;
  localparam logic [2:0] S_SHIFT = 3'b010;
  localparam logic [2:0] S_MOVE  = 3'b011;
  localparam logic [2:0] S_ARITH = 3'b100;
  localparam logic [2:0] S_MUL   = 3'b101;

  localparam logic [7:0] C_NOP   = 8'h00;
  localparam logic [7:0] C_OR    = 8'b0010_0101;
  localparam logic [7:0] C_NOR   = 8'b0010_0111;
  localparam logic [7:0] C_SRA   = 8'b0000_0011;
  localparam logic [7:0] C_MFHI  = 8'b0001_0000;
  localparam logic [7:0] C_MTHI  = 8'b0001_0001;
  localparam logic [7:0] C_MTLO  = 8'b0001_0011;
  localparam logic [7:0] C_SLT   = 8'b0010_1010;
  localparam logic [7:0] C_SLTU  = 8'b0010_1011;
  localparam logic [7:0] C_ADD   = 8'b0010_0000;
  localparam logic [7:0] C_ADDU  = 8'b0010_0001;
  localparam logic [7:0] C_SUB   = 8'b0010_0010;
  localparam logic [7:0] C_CLZ   = 8'b1011_0000;
  localparam logic [7:0] C_CLO   = 8'b1011_0001;
  localparam logic [7:0] C_MULT  = 8'b0001_1000;
  localparam logic [7:0] C_MULTU = 8'b0001_1001;
  localparam logic [7:0] C_MUL   = 8'b1010_1001;
  localparam logic [7:0] C_MADD  = 8'b1010_0110;
  localparam logic [7:0] C_DIV   = 8'b0001_1010;
  localparam logic [7:0] C_DIVU  = 8'b0001_1011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  alu_op;
  logic [2:0]  alu_sel;
  logic [31:0] op0, op1;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic        fwd_wen, mem_wen, stall_req;
  logic [4:0]  fwd_waddr, mem_waddr;
  logic [31:0] fwd_wdata, mem_wdata, hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage #(.N_REG(32), .N_REG_ADDR(5), .N_ALU_OP(8), .N_ALU_SEL(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_op(alu_op), .i_alu_sel(alu_sel),
    .i_op_reg_0(op0), .i_op_reg_1(op1),
    .i_reg_wen(reg_wen), .i_reg_waddr(reg_waddr),
    .o_fwd_wen(fwd_wen), .o_fwd_waddr(fwd_waddr), .o_fwd_wdata(fwd_wdata),
    .o_mem_wen(mem_wen), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
    .o_hi(hi), .o_lo(lo), .o_stall_req(stall_req)
  );

  // Present one instruction at the falling edge; it is registered at the next rising edge.
  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic wen, input logic [4:0] waddr);
    @(negedge clk);
    alu_op = op; alu_sel = sel; op0 = a; op1 = b; reg_wen = wen; reg_waddr = waddr;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    alu_op = C_NOP; alu_sel = S_NOP; op0 = '0; op1 = '0; reg_wen = 1'b0; reg_waddr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_wen: got %0h expected 0", mem_wen); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (mem_waddr !== 5'h0) begin errors++; $display("FAIL reset_mem_waddr: got %h expected 0", mem_waddr); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h expected 0", stall_req); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow;
    drive(C_ADD, S_ARITH, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd5);
    #1;
    checks++; if (fwd_wen !== 1'b0) begin errors++; $display("FAIL add_ov_fwd_wen: got %0h expected 0", fwd_wen); end
    @(posedge clk); #1;
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL add_ov_mem_wen: got %0h expected 0", mem_wen); end
    drive(C_ADDU, S_ARITH, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd5);
    #1;
    checks++; if (fwd_wdata !== 32'h8000_0000) begin errors++; $display("FAIL addu_fwd_wdata: got %h expected 80000000", fwd_wdata); end
    @(posedge clk); #1;
    checks++; if ({mem_wen, mem_waddr, mem_wdata} !== {1'b1, 5'd5, 32'h8000_0000})
      begin errors++; $display("FAIL addu_mem: got %0h/%0d/%h expected 1/5/80000000", mem_wen, mem_waddr, mem_wdata); end
    drive(C_SUB, S_ARITH, 32'h8000_0000, 32'h1, 1'b1, 5'd6);
    #1;
    checks++; if (fwd_wen !== 1'b0) begin errors++; $display("FAIL sub_ov_fwd_wen: got %0h expected 0", fwd_wen); end
  endtask

  task automatic test_alu;
    logic [7:0]  ops  [8] = '{C_SRA, C_SLTU, C_SLT, C_OR, C_NOR, C_CLZ, C_CLO, C_CLZ};
    logic [2:0]  sels [8] = '{S_SHIFT, S_ARITH, S_ARITH, S_LOGIC, S_LOGIC, S_ARITH, S_ARITH, S_ARITH};
    logic [31:0] a    [8] = '{32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_0000, 32'h0, 32'h0001_0000, 32'hFFFF_0000, 32'h0};
    logic [31:0] b    [8] = '{32'h8000_0010, 32'h1, 32'h1, 32'h0000_0F0F, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] exp  [8] = '{32'hF800_0001, 32'h0, 32'h1, 32'hF0F0_0F0F, 32'hFFFF_FFFF, 32'd15, 32'd16, 32'd32};
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], sels[i], a[i], b[i], 1'b1, 5'(i + 1));
      @(posedge clk); #1;
      checks++;
      if ({mem_wen, mem_wdata} !== {1'b1, exp[i]})
        begin errors++; $display("FAIL alu_vec%0d: got wen=%0h data=%h expected wen=1 data=%h", i, mem_wen, mem_wdata, exp[i]); end
    end
  endtask

  task automatic test_mult_move;
    drive(C_MULT, S_ARITH, 32'hFFFF_FFFE, 32'd3, 1'b1, 5'd7);
    #1;
    checks++; if (fwd_wen !== 1'b0) begin errors++; $display("FAIL mult_fwd_wen: got %0h expected 0", fwd_wen); end
    @(posedge clk); #1;
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_hilo: got %h expected FFFFFFFFFFFFFFFA", {hi, lo}); end
    drive(C_MFHI, S_MOVE, 32'h0, 32'h0, 1'b1, 5'd8);
    @(posedge clk); #1;
    checks++; if (mem_wdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mfhi: got %h expected FFFFFFFF", mem_wdata); end
    drive(C_MUL, S_MUL, 32'hFFFF_FFFE, 32'd3, 1'b1, 5'd9);
    @(posedge clk); #1;
    checks++; if (mem_wdata !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mul_data: got %h expected FFFFFFFA", mem_wdata); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mul_hilo_kept: got %h expected FFFFFFFFFFFFFFFA", {hi, lo}); end
    drive(C_MULTU, S_ARITH, 32'hFFFF_FFFF, 32'd2, 1'b0, 5'd0);
    @(posedge clk); #1;
    checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL multu_hilo: got %h expected 00000001FFFFFFFE", {hi, lo}); end
    drive(C_MTHI, S_NOP, 32'h1234_5678, 32'h0, 1'b0, 5'd0);
    drive(C_MTLO, S_NOP, 32'h9ABC_DEF0, 32'h0, 1'b0, 5'd0);
    @(posedge clk); #1;
    checks++; if ({hi, lo} !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL mthi_mtlo: got %h expected 123456789ABCDEF0", {hi, lo}); end
  endtask

  task automatic test_div;
    int n;
    drive(C_DIV, S_NOP, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd3);
    #1;
    n = 0;
    while (stall_req === 1'b1 && n < 40) begin
      if (n == 5) begin
        checks++; if (fwd_wen !== 1'b0) begin errors++; $display("FAIL div_bubble_wen: got %0h expected 0", fwd_wen); end
      end
      n++;
      @(negedge clk); #1;
    end
    checks++; if (n != 33) begin errors++; $display("FAIL div_stall_cycles: got %0d expected 33", n); end
    @(posedge clk); #1;
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_hilo: got %h expected FFFFFFFFFFFFFFFD", {hi, lo}); end
    // The same DIV still presented after DONE must not restart.
    @(negedge clk); #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL div_no_rerun: got %0h expected 0", stall_req); end
    drive(C_DIVU, S_NOP, 32'd55, 32'd0, 1'b0, 5'd0);
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL div0_stall: got %0h expected 0", stall_req); end
    @(posedge clk); #1;
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div0_hilo: got %h expected FFFFFFFFFFFFFFFD", {hi, lo}); end
    drive(C_NOP, S_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic test_div_reset_abort;
    int n;
    drive(C_DIVU, S_NOP, 32'd100, 32'd7, 1'b0, 5'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    alu_op = C_NOP; op0 = '0; op1 = '0;
    @(posedge clk); #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL abort_stall: got %0h expected 0", stall_req); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(C_DIVU, S_NOP, 32'd100, 32'd7, 1'b0, 5'd0);
    #1;
    n = 0;
    while (stall_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    checks++; if (n != 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d expected 33", n); end
    @(posedge clk); #1;
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_hilo: got %h expected 000000020000000E", {hi, lo}); end
    drive(C_NOP, S_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic test_madd;
    drive(C_MTHI, S_NOP, 32'd0, 32'd0, 1'b0, 5'd0);
    drive(C_MTLO, S_NOP, 32'd5, 32'd0, 1'b0, 5'd0);
    drive(C_MADD, S_ARITH, 32'd3, 32'd4, 1'b1, 5'd2);
    #1;
    checks++; if (fwd_wen !== 1'b0) begin errors++; $display("FAIL madd_wen: got %0h expected 0", fwd_wen); end
`ifdef EX_MADD_EN
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL madd_stall1: got %0h expected 1", stall_req); end
    @(negedge clk); #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL madd_stall2: got %0h expected 0", stall_req); end
    @(posedge clk); #1;
    checks++; if ({hi, lo} !== {32'd0, 32'd17}) begin errors++; $display("FAIL madd_hilo: got %h expected 0000000000000011", {hi, lo}); end
`else
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL madd_off_stall: got %0h expected 0", stall_req); end
    checks++; if (fwd_wdata !== 32'h0) begin errors++; $display("FAIL madd_off_data: got %h expected 0", fwd_wdata); end
    @(posedge clk); #1;
    checks++; if ({hi, lo} !== {32'd0, 32'd5}) begin errors++; $display("FAIL madd_off_hilo: got %h expected 0000000000000005", {hi, lo}); end
`endif
    drive(C_NOP, S_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_alu();
    test_mult_move();
    test_div();
    test_div_reset_abort();
    test_madd();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage OpenMIPS pipeline.
- Consumes the decoded bundle from the ID/EX register: alu_op, alu_sel, two operands, and write enable/address.
- Computes logic, shift, move, arithmetic and multiply results. Owns the HI/LO registers and an iterative 32-cycle divider.
- Drives combinational forwarding back to ID, the registered EX/MEM bundle, and a stall request to pipeline control.

Parameters:
- N_REG, 32, datapath width.
- N_REG_ADDR, 5, register address width.
- N_ALU_OP, 8, alu_op width (encodings from defines.svh).
- N_ALU_SEL, 3, alu_sel width (encodings from defines.svh).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_alu_op  in  N_ALU_OP  operation subtype
- i_alu_sel  in  N_ALU_SEL  result class
- i_op_reg_0  in  N_REG  operand 0 (rs, or shamt for immediate shifts)
- i_op_reg_1  in  N_REG  operand 1 (rt or immediate)
- i_reg_wen  in  1  destination write enable from ID
- i_reg_waddr  in  N_REG_ADDR  destination address
- o_fwd_wen  out  1  combinational write enable to ID forwarding
- o_fwd_waddr  out  N_REG_ADDR  combinational destination address to ID forwarding
- o_fwd_wdata  out  N_REG  combinational result to ID forwarding
- o_mem_wen  out  1  registered write enable to MEM
- o_mem_waddr  out  N_REG_ADDR  registered destination address to MEM
- o_mem_wdata  out  N_REG  registered result to MEM
- o_hi  out  N_REG  HI register
- o_lo  out  N_REG  LO register
- o_stall_req  out  1  hold IF/ID/EX stages

Behaviour:
- Reset: i_rst_n, synchronous, active-low. On reset all registered outputs are 0 and o_stall_req=0. HI=LO=0 and the divider state is IDLE. Reset mid-divide aborts the divide with no HI/LO write.
- Result select: i_alu_sel picks one of LOGIC, SHIFT, MOVE, ARITHMETIC or MUL; NOP gives 0.
- LOGIC: OR/AND/XOR/NOR on the two operands.
- SHIFT: SLL/SRL/SRA shift op_reg_1 by op_reg_0[4:0]. SRA sign-fills.
- MOVE:
  - MFHI/MFLO return HI/LO.
  - MOVN/MOVZ return op_reg_0.
  - MTHI/MTLO write op_reg_0 to HI/LO at the clock edge.
- ARITHMETIC:
  - ADD/ADDU/ADDI/ADDIU produce a 32-bit sum; SUB/SUBU produce op0-op1.
  - ADD/ADDI/SUB signed overflow forces the write enable to 0 and the result is discarded.
  - SLT is a signed compare; SLTU is unsigned. Result is 1 or 0.
  - CLZ/CLO count leading zeros/ones of op0 (0..32).
  - MULT/MULTU produce a 64-bit product: {HI,LO} written at the edge, register write enable 0.
- MUL: low 32 bits of the signed product go to the destination register; HI/LO unchanged.
- Forwarding outputs: o_fwd_* are combinational in the same cycle, equal to the values about to be registered into o_mem_*.
- Registered outputs: o_mem_* take o_fwd_* at the edge, giving 1-cycle latency.
- Stall bubble: while o_stall_req=1, o_fwd_wen=0 and a bubble (wen=0) is registered.
- Divider FSM, states IDLE -> BUSY -> DONE -> IDLE:
  - IDLE + DIV/DIVU with op1!=0: latch the operands, enter BUSY, assert o_stall_req the same cycle.
  - BUSY: radix-2 restoring, one quotient bit per cycle, 32 cycles; stall held.
  - DONE: LO=quotient and HI=remainder written at this edge. o_stall_req=0 in DONE so the pipeline advances. Return to IDLE.
  - Signed DIV: operate on magnitudes. Quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero: no BUSY, no stall, HI/LO unchanged.
  - Upstream holds inputs stable while stalled. Re-presentation of the same DIV after DONE is not re-executed; a one-shot done flag is cleared when the next non-stalled instruction is accepted.
- HI/LO write priority per edge: divider DONE > MULT/MULTU > MTHI/MTLO. Only one occurs per cycle by construction.

Optional Feature:
- Macro: EX_MADD_EN.
- When defined:
  - Adds MADD, MADDU, MSUB and MSUBU (alu_sel ARITHMETIC) as a 2-cycle operation.
  - Cycle 1: the 64-bit product is registered and o_stall_req=1.
  - Cycle 2: {HI,LO} = {HI,LO} ± product, written at the edge; stall deasserts.
  - No register write.
- When undefined: these opcodes decode to result 0 with wen=0 and no HI/LO change.

Test Plan:
- ADD with op0=0x7FFFFFFF, op1=1, wen=1 -> o_fwd_wen=0, o_mem_wen=0 next cycle. ADDU with the same operands -> o_mem_wdata=0x80000000, wen=1.
- SRA with op0=4, op1=0x80000010 -> 0xF8000001. SLTU with op0=0xFFFFFFFF, op1=1 -> 0. SLT with the same operands -> 1.
- MULT with op0=0xFFFFFFFE (-2), op1=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. Next cycle MFHI -> o_mem_wdata=0xFFFFFFFF.
- DIV with op0=-7, op1=2 -> o_stall_req high for 33 cycles then low. Then LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU with op1=0 -> no stall, HI/LO unchanged.
- Reset pulsed at BUSY cycle 10 of a DIVU 100/7 -> stall drops at the next edge, HI=LO=0, the next DIVU 100/7 completes with LO=14 and HI=2.
- EX_MADD_EN with HI=0, LO=5, MADD 3×4 -> 1 stall cycle, then LO=17 and HI=0. Without the macro -> HI/LO unchanged, no stall.
